// File: rtl/rs232_cmd_sequencer_if.sv
// Byte handshake and register-bank control bundle between the RS232 command
// sequencer (master) and the UART / register banks (slave).
interface rs232_cmd_sequencer_if;
   logic [7:0] rxdw;
   logic       rxrdy;
   logic       txbusy;
   logic       txena;
   logic       shift_rxregs;
   logic       load_confregs;
   logic       load_txregs;
   logic       shift_txregs;
   logic       done;
   logic       err;
   logic [7:0] sleds;

   // valid/ready: rxrdy is a one-cycle valid for rxdw with no back-pressure;
   // txena is a one-cycle request, acknowledged by txbusy rising and completed
   // by txbusy falling. All other controls are one-cycle strobes.
   modport master (
      input  rxdw, rxrdy, txbusy,
      output txena, shift_rxregs, load_confregs, load_txregs, shift_txregs,
             done, err, sleds
   );

   modport slave (
      output rxdw, rxrdy, txbusy,
      input  txena, shift_rxregs, load_confregs, load_txregs, shift_txregs,
             done, err, sleds
   );
endinterface

// File: rtl/rs232_cmd_sequencer.sv
// Command sequencer for the RS232 configuration link: decodes 'W'/'R' and
// sequences the NBYTES write or readback with an inter-byte timeout.
module rs232_cmd_sequencer #(
   parameter int         NBYTES  = 4,
   parameter logic [7:0] WR_CMD  = 8'h57,
   parameter logic [7:0] RD_CMD  = 8'h52,
   parameter int         TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic rst,
   rs232_cmd_sequencer_if.master bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [3:0] IDLE        = 4'd0;
   localparam logic [3:0] WR_WAIT     = 4'd1;
   localparam logic [3:0] WR_SHIFT    = 4'd2;
   localparam logic [3:0] WR_LOAD     = 4'd3;
   localparam logic [3:0] RD_LOAD     = 4'd4;
   localparam logic [3:0] RD_WAITFREE = 4'd5;
   localparam logic [3:0] RD_START    = 4'd6;
   localparam logic [3:0] RD_WAITACK  = 4'd7;
   localparam logic [3:0] RD_WAITEND  = 4'd8;
   localparam logic [3:0] RD_SHIFT    = 4'd9;

   localparam logic [7:0]    LAST  = 8'(NBYTES);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);

   logic [3:0]    state, state_nx;
   logic [7:0]    cnt, cnt_nx;
   logic [TW-1:0] tcnt;
   logic          expired, waiting, err_nx;

   logic txena_q, shift_rx_q, load_conf_q, load_tx_q, shift_tx_q, done_q, err_q;
   logic [7:0] sleds_q;

   assign expired = (tcnt == T_MAX);
   assign waiting = (state == WR_WAIT) || (state == RD_WAITFREE) ||
                    (state == RD_WAITACK) || (state == RD_WAITEND);

   // cnt is bumped on the edge entering a SHIFT state, so inside SHIFT it
   // already holds the number of bytes moved so far.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      err_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rxrdy && bus.rxdw == WR_CMD) begin
               state_nx = WR_WAIT;
               cnt_nx   = '0;
            end else if (bus.rxrdy && bus.rxdw == RD_CMD) begin
               state_nx = RD_LOAD;
               cnt_nx   = '0;
            end
         end
         WR_WAIT: begin
            if (bus.rxrdy) begin
               state_nx = WR_SHIFT;
               cnt_nx   = cnt + 8'd1;
            end else if (expired) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end
         end
         WR_SHIFT:    state_nx = (cnt == LAST) ? WR_LOAD : WR_WAIT;
         WR_LOAD:     state_nx = IDLE;
         RD_LOAD:     state_nx = RD_WAITFREE;
         RD_WAITFREE: begin
            if (!bus.txbusy) begin
               state_nx = RD_START;
            end else if (expired) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end
         end
         RD_START:    state_nx = RD_WAITACK;
         RD_WAITACK: begin
            if (bus.txbusy) begin
               state_nx = RD_WAITEND;
            end else if (expired) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end
         end
         RD_WAITEND: begin
            if (!bus.txbusy) begin
               state_nx = RD_SHIFT;
               cnt_nx   = cnt + 8'd1;
            end else if (expired) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
            end
         end
         RD_SHIFT:    state_nx = (cnt == LAST) ? IDLE : RD_WAITFREE;
         default:     state_nx = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each strobe is registered
   // and coincides with the cycle the FSM spends in the matching state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         tcnt        <= '0;
         txena_q     <= 1'b0;
         shift_rx_q  <= 1'b0;
         load_conf_q <= 1'b0;
         load_tx_q   <= 1'b0;
         shift_tx_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         sleds_q     <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         tcnt        <= (state_nx != state || !waiting) ? '0 : tcnt + TW'(1);
         shift_rx_q  <= (state_nx == WR_SHIFT);
         load_conf_q <= (state_nx == WR_LOAD);
         load_tx_q   <= (state_nx == RD_LOAD);
         txena_q     <= (state_nx == RD_START);
         shift_tx_q  <= (state_nx == RD_SHIFT);
         done_q      <= (state_nx == WR_LOAD) ||
                        (state_nx == RD_SHIFT && cnt_nx == LAST);
         err_q       <= err_nx;
         sleds_q     <= {cnt_nx[3:0], state_nx};
      end
   end

   assign bus.txena         = txena_q;
   assign bus.shift_rxregs  = shift_rx_q;
   assign bus.load_confregs = load_conf_q;
   assign bus.load_txregs   = load_tx_q;
   assign bus.shift_txregs  = shift_tx_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
   assign bus.sleds         = sleds_q;

endmodule

// File: doc/rs232_cmd_sequencer.md
Name: rs232_cmd_sequencer

Overview:
Single-FSM command sequencer for the RS232 configuration link, sitting between the UART (rx/tx byte handshakes) and the rx/config/tx register banks. It decodes a command byte, then sequences either an NBYTES write (shift received bytes in, then load the config registers) or an NBYTES readback (load the tx registers, then transmit and shift byte by byte). Includes an inter-byte timeout, error reporting and status LEDs.

Parameters:
NBYTES, 4, number of data bytes per write or read transaction (1..255).
WR_CMD, 8'h57, command byte ('W') that starts a write.
RD_CMD, 8'h52, command byte ('R') that starts a readback.
TIMEOUT, 1000000, max idle cycles while waiting on rxrdy or a txbusy edge before aborting (20 ms at 50 MHz).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rxdw  in  8  received byte, valid while rxrdy=1
rxrdy  in  1  one-cycle pulse: new byte on rxdw
txbusy  in  1  UART transmitter busy level
txena  out  1  one-cycle pulse: start transmission of current tx_regs head byte
shift_rxregs  out  1  one-cycle pulse: shift rxdw into rx register chain
load_confregs  out  1  one-cycle pulse: copy rx registers into config registers
load_txregs  out  1  one-cycle pulse: copy config registers into tx registers
shift_txregs  out  1  one-cycle pulse: advance tx register chain to next byte
done  out  1  one-cycle pulse: transaction completed successfully
err  out  1  one-cycle pulse: transaction aborted (timeout)
sleds  out  8  [3:0] state code, [7:4] byte counter low nibble

Behaviour:
- Clocking: single clk domain; rst is synchronous, active-high. All outputs are registered.
- Reset: state IDLE, byte counter 0, timeout counter 0, all pulse outputs 0, sleds 0. Reset mid-transaction aborts it silently (no done, no err).
- Pulses: every control output is high for exactly one cycle.
- Pulse latency: one cycle after the clock edge where the triggering condition is sampled.
- State codes: IDLE=0, WR_WAIT=1, WR_SHIFT=2, WR_LOAD=3, RD_LOAD=4, RD_WAITFREE=5, RD_START=6, RD_WAITACK=7, RD_WAITEND=8, RD_SHIFT=9.
- IDLE:
  - rxrdy with rxdw==WR_CMD -> WR_WAIT, cnt=0.
  - rxrdy with rxdw==RD_CMD -> RD_LOAD, cnt=0.
  - Any other byte is ignored (stay IDLE, no err).
- WR_WAIT:
  - rxrdy -> WR_SHIFT.
  - TIMEOUT cycles with no rxrdy -> err pulse, IDLE, config unchanged.
- WR_SHIFT: shift_rxregs=1, cnt+1.
  - If cnt+1==NBYTES -> WR_LOAD; else WR_WAIT.
- WR_LOAD: load_confregs=1 and done=1 in the same cycle -> IDLE.
- RD_LOAD: load_txregs=1 -> RD_WAITFREE.
- RD_WAITFREE: wait for txbusy==0 -> RD_START.
- RD_START: txena=1 -> RD_WAITACK.
- RD_WAITACK: wait for txbusy==1 -> RD_WAITEND.
- RD_WAITEND: wait for txbusy==0 -> RD_SHIFT.
- RD_SHIFT: shift_txregs=1, cnt+1.
  - If cnt+1==NBYTES -> done=1 in the same cycle -> IDLE; else RD_WAITFREE.
- Byte order: the first byte transmitted is the tx_regs head as loaded, before any shift. Exactly NBYTES txena and NBYTES shift_txregs pulses per read.
- Timeout:
  - Counter clears on every state change.
  - Counts in WR_WAIT, RD_WAITFREE, RD_WAITACK, RD_WAITEND.
  - Expiry (count==TIMEOUT-1) -> err pulse, IDLE, no done.
- rxrdy in any state other than IDLE/WR_WAIT is ignored; command bytes received during a read do not restart the FSM.
- Simultaneous events: rxrdy on the same cycle as timeout expiry in WR_WAIT -> rxrdy wins (WR_SHIFT).
- Mutual exclusion: shift_rxregs, load_confregs, load_txregs, txena and shift_txregs are never high together.
- Counters: cnt is 8 bits and never wraps within a transaction (NBYTES≤255); timeout counter is $clog2(TIMEOUT+1) bits.

Test Plan:
- Write, NBYTES=4, TIMEOUT=100: rxrdy with 8'h57, then 4 bytes (8'h11,22,33,44) spaced 10 cycles -> 4 shift_rxregs pulses, each 1 cycle after its rxrdy; then load_confregs+done 1 cycle after the 4th shift; FSM back in IDLE (sleds[3:0]=0).
- Read, txbusy model 1 cycle after txena, high 20 cycles: rxrdy with 8'h52 -> load_txregs next cycle, then 4 txena / 4 shift_txregs alternating; done with the 4th shift; no txena while txbusy=1.
- Write timeout: 'W' + 2 bytes, then silence -> err pulse exactly 100 cycles after entering WR_WAIT; no load_confregs; a following 'W' + 4 bytes completes normally.
- Read stall: txbusy never rises after txena -> err 100 cycles later, IDLE; no shift_txregs for that byte.
- Unknown command 8'h41 and rxrdy bytes during an active read -> no outputs, no err, read still completes with exactly 4 txena.
- Synchronous reset asserted in WR_WAIT after 2 bytes -> next edge: all outputs 0, sleds=0; no done/err; a subsequent 'R' transaction runs normally.
